// File: rtl/float_rec_requester.sv
// Initiator for the enable/ack handshake of a shared iterative reciprocal unit.
// One operand in flight: accept, restart the unit, wait for ack (or time out), hand back the result.
module float_rec_requester #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64,
  parameter int TO_W       = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] number_o,
  output logic                  enable_o,
  input  logic                  ack_i,
  input  logic [DATA_WIDTH-1:0] output_rec_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  timeout_err_o
);

  localparam int EXP_MSB = DATA_WIDTH - 2;
  localparam int EXP_LSB = DATA_WIDTH - 9;
  localparam int MAN_W   = DATA_WIDTH - 9;
  localparam logic [TO_W-1:0] LAST_COUNT = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    BYPASS,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] number_q, number_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  in_ready_q, in_ready_d;
  logic [TO_W-1:0]       count_q, count_d;

  logic [DATA_WIDTH-1:0] quiet_nan;
  logic [DATA_WIDTH-1:0] signed_inf;

  assign quiet_nan  = {number_q[DATA_WIDTH-1], 8'hFF, 1'b1, {(MAN_W-1){1'b0}}};
  assign signed_inf = {number_q[DATA_WIDTH-1], 8'hFF, {MAN_W{1'b0}}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      number_q      <= '0;
      out_data_q    <= '0;
      timeout_err_q <= 1'b0;
      in_ready_q    <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      number_q      <= number_d;
      out_data_q    <= out_data_d;
      timeout_err_q <= timeout_err_d;
      in_ready_q    <= in_ready_d;
      count_q       <= count_d;
    end
  end

  // ARM always spends one cycle with enable low so the unit restarts cleanly between ops.
  always_comb begin
    state_d       = state_q;
    number_d      = number_q;
    out_data_d    = out_data_q;
    timeout_err_d = 1'b0;
    count_d       = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_q) begin
          number_d = in_data_i;
          state_d  = (in_data_i[EXP_MSB:EXP_LSB] == '0) ? BYPASS : ARM;
        end
      end
      ARM: begin
        count_d = '0;
        state_d = RUN;
      end
      RUN: begin
        // A late ack on the final allowed cycle still wins over the timeout.
        if (ack_i) begin
          out_data_d = output_rec_i;
          state_d    = DONE;
        end else if (count_q == LAST_COUNT) begin
          out_data_d    = quiet_nan;
          timeout_err_d = 1'b1;
          state_d       = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      BYPASS: begin
        out_data_d = signed_inf;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  assign in_ready_o    = in_ready_q;
  assign number_o      = number_q;
  assign enable_o      = (state_q == RUN);
  assign out_data_o    = out_data_q;
  assign out_valid_o   = (state_q == DONE);
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_float_rec_requester.sv
// Bench for float_rec_requester: mock reciprocal unit, timeline model of each operation,
// one negedge compare process, plus directed scenarios with hand-computed literals.
module tb_float_rec_requester;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] inData;
  logic        inValid;
  logic        inReady;
  logic [31:0] number;
  logic        enable;
  logic        ack;
  logic [31:0] outputRec;
  logic [31:0] outData;
  logic        outValid;
  logic        outReady;
  logic        timeoutErr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  float_rec_requester #(
    .DATA_WIDTH(32),
    .TIMEOUT   (TIMEOUT),
    .TO_W      (7)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .in_data_i    (inData),
    .in_valid_i   (inValid),
    .in_ready_o   (inReady),
    .number_o     (number),
    .enable_o     (enable),
    .ack_i        (ack),
    .output_rec_i (outputRec),
    .out_data_o   (outData),
    .out_valid_o  (outValid),
    .out_ready_i  (outReady),
    .timeout_err_o(timeoutErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mock unit: acks during its mockLat-th cycle of enable high, result is the sign-flipped operand.
  int mockLat = 5;
  bit mockAck = 1'b1;
  int mockCnt = 0;
  always @(posedge clk) begin
    if (!enable) mockCnt <= 0;
    else         mockCnt <= mockCnt + 1;
  end
  assign ack       = enable && mockAck && (mockCnt == mockLat - 1);
  assign outputRec = number ^ 32'h8000_0000;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Model state: one operation described by its accept cycle and the phases that follow it.
  bit          busy = 1'b0;
  int          opC;
  logic [31:0] opD;
  logic [31:0] opRes;
  bit          opByp;
  bit          opTo;
  int          opL;
  logic        prevValid = 1'b0;
  logic [31:0] resQ[$];
  int          lastLat = -1;
  int          errCount = 0;
  int          enCount = 0;

  always @(negedge clk) begin : compare
    int   k;
    logic expRdy, expEn, expVal, expErr;
    if (!rstN) begin
      checkOutput("reset in_ready", inReady, 0);
      checkOutput("reset enable", enable, 0);
      checkOutput("reset out_valid", outValid, 0);
      checkOutput("reset timeout_err", timeoutErr, 0);
      checkOutput("reset out_data", outData, 32'h0);
      checkOutput("reset number", number, 32'h0);
      busy      = 1'b0;
      prevValid = 1'b0;
    end else begin
      k      = cyc - opC;
      expRdy = !busy;
      expEn  = busy && !opByp && (k >= 2) && (k <= 1 + opL);
      expVal = busy && (opByp ? (k >= 2) : (k >= 2 + opL));
      expErr = busy && !opByp && opTo && (k == 2 + opL);
      checkOutput("in_ready", inReady, expRdy);
      checkOutput("enable", enable, expEn);
      checkOutput("out_valid", outValid, expVal);
      checkOutput("timeout_err", timeoutErr, expErr);
      if (expEn) checkOutput("number", number, opD);
      if (expVal) checkOutput("out_data", outData, opRes);
      if (timeoutErr) errCount++;
      if (enable) enCount++;
      if (outValid && !prevValid) lastLat = k;
      if (outValid && outReady) resQ.push_back(outData);
      prevValid = outValid;
      if (expVal && outReady) begin
        busy = 1'b0;
      end else if (!busy && inValid) begin
        busy  = 1'b1;
        opC   = cyc;
        opD   = inData;
        opByp = (inData[30:23] == 8'h00);
        opTo  = !(mockAck && mockLat <= TIMEOUT);
        opL   = opTo ? TIMEOUT : mockLat;
        if (opByp)     opRes = {inData[31], 8'hFF, 23'h0};
        else if (opTo) opRes = {inData[31], 8'hFF, 23'h40_0000};
        else           opRes = inData ^ 32'h8000_0000;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] d, input bit hold);
    inValid = 1'b1;
    inData  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (inReady) begin
        @(posedge clk);
        #1;
        if (!hold) inValid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    failNow("accept");
    inValid = 1'b0;
  endtask

  task automatic waitResults(input int n, input string name);
    for (int i = 0; i < 300; i++) begin
      if (resQ.size() >= n) return;
      @(posedge clk);
      #1;
    end
    failNow(name);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    int errBase, enBase;
    rstN     = 1'b0;
    inValid  = 1'b0;
    inData   = 32'h0;
    outReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rstN = 1'b1;
    @(posedge clk);
    #1;

    // Single operation through the mock unit.
    resQ.delete();
    enBase = enCount;
    applyStimulus(32'h3EB0_A3D7, 1'b0);
    waitResults(1, "t1 result");
    if (resQ.size() >= 1) checkOutput("t1 data", resQ[0], 32'hBEB0_A3D7);
    checkOutput("t1 latency", lastLat, 7);
    checkOutput("t1 enable cycles", enCount - enBase, 5);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back with in_valid held.
    resQ.delete();
    applyStimulus(32'h3EB0_A3D7, 1'b1);
    applyStimulus(32'hBEFE_F9DB, 1'b0);
    waitResults(2, "t2 results");
    if (resQ.size() >= 2) begin
      checkOutput("t2 first", resQ[0], 32'hBEB0_A3D7);
      checkOutput("t2 second", resQ[1], 32'h3EFE_F9DB);
    end
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: hold the result for ten cycles.
    resQ.delete();
    outReady = 1'b0;
    applyStimulus(32'h3F80_0000, 1'b0);
    for (int i = 0; i < 50 && !outValid; i++) @(posedge clk);
    #1;
    if (!outValid) failNow("t3 valid");
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t3 held data", outData, 32'hBF80_0000);
    outReady = 1'b1;
    waitResults(1, "t3 result");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t3 transfers", resQ.size(), 1);

    // Zero operand bypasses the unit.
    resQ.delete();
    enBase = enCount;
    applyStimulus(32'h8000_0000, 1'b0);
    waitResults(1, "t4 result");
    if (resQ.size() >= 1) checkOutput("t4 data", resQ[0], 32'hFF80_0000);
    checkOutput("t4 latency", lastLat, 2);
    checkOutput("t4 enable cycles", enCount - enBase, 0);
    repeat (2) @(posedge clk);
    #1;

    // Unit never acks: positive and negative operands time out.
    mockAck = 1'b0;
    resQ.delete();
    errBase = errCount;
    applyStimulus(32'h3F00_0000, 1'b0);
    waitResults(1, "t5 result");
    if (resQ.size() >= 1) checkOutput("t5 data", resQ[0], 32'h7FC0_0000);
    checkOutput("t5 latency", lastLat, 66);
    checkOutput("t5 err pulses", errCount - errBase, 1);
    resQ.delete();
    applyStimulus(32'hBF80_0000, 1'b0);
    waitResults(1, "t5b result");
    if (resQ.size() >= 1) checkOutput("t5b data", resQ[0], 32'hFFC0_0000);

    // Ack on the final allowed cycle beats the timeout.
    mockAck = 1'b1;
    mockLat = TIMEOUT;
    resQ.delete();
    errBase = errCount;
    applyStimulus(32'h4049_0FDB, 1'b0);
    waitResults(1, "t5c result");
    if (resQ.size() >= 1) checkOutput("t5c data", resQ[0], 32'hC049_0FDB);
    checkOutput("t5c latency", lastLat, 66);
    checkOutput("t5c err pulses", errCount - errBase, 0);
    mockLat = 5;
    repeat (2) @(posedge clk);
    #1;

    // Reset asserted while the unit is running.
    resQ.delete();
    applyStimulus(32'h3EB0_A3D7, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #3 rstN = 1'b0;
    #1;
    checkOutput("t6 async enable", enable, 0);
    checkOutput("t6 async out_valid", outValid, 0);
    checkOutput("t6 async in_ready", inReady, 0);
    @(negedge clk);
    #2 rstN = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(32'h3F80_0000, 1'b0);
    waitResults(1, "t6 result");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t6 transfers", resQ.size(), 1);
    if (resQ.size() >= 1) checkOutput("t6 data", resQ[0], 32'hBF80_0000);
    checkOutput("t6 latency", lastLat, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
